// File: rtl/jtpcm_nch.sv
// NCH-channel 7-bit PCM player. All channels share one ROM port through a
// round-robin prefetch arbiter, and the per-channel samples are mixed with 4-bit gains.
module jtpcm_nch #(
    parameter int NCH = 2,
    parameter int AW  = 17,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic [5:0]      addr,
    input  logic            we,
    input  logic [7:0]      din,
    output logic [7:0]      dout,
    output logic            cen_e,
    output logic            cen_q,
    output logic [AW-1:0]   rom_addr,
    output logic            rom_cs,
    input  logic            rom_ok,
    input  logic [7:0]      rom_dout,
    output logic [NCH-1:0]  underrun,
    output logic [10+CW:0]  snd
);
    localparam int IW = (NCH > 1) ? CW : 1;

    typedef enum logic { IDLE, WAIT } state_t;
    state_t state, state_nxt;

    logic [1:0]    tick;
    logic [11:0]   pre    [NCH];
    logic [1:0]    presel [NCH];
    logic [AW-1:0] start  [NCH];
    logic [AW-1:0] ptr    [NCH];
    logic [3:0]    gain   [NCH];
    logic [11:0]   cnt    [NCH];
    logic [7:0]    sbuf   [NCH];
    logic [6:0]    snd_c  [NCH];

    logic [NCH-1:0] busy, valid, loop_en, over, keyon, stop, req, loop_rst;
    logic [IW-1:0]  cur, last, pick;
    logic           found, first, discard, issue, complete;
    logic [2:0]     wr_ch, wr_idx;
    logic           wr_ok;
    logic [10+CW:0] mix;
    logic [7:0]     dout_nxt;

    function automatic logic div_over(input logic [11:0] c, input logic [1:0] sel);
        if (sel[0]) return &c[7:0];
        if (sel[1]) return &c[11:8];
        return &c;
    endfunction

    function automatic logic [10:0] weight(input logic [6:0] s, input logic [3:0] g);
        return 11'(s) * 11'(g);
    endfunction

    // Returns {found, channel}: nearest requester after 'from' in round-robin order.
    function automatic logic [IW:0] rr_pick(input logic [NCH-1:0] r, input logic [IW-1:0] from);
        int best;
        int d;
        logic [IW:0] res;
        best = NCH;
        res  = '0;
        for (int j = 0; j < NCH; j++) begin
            d = (j + 2 * NCH - int'(from) - 1) % NCH;
            if (r[j] && d < best) begin
                best = d;
                res  = {1'b1, IW'(j)};
            end
        end
        return res;
    endfunction

    always_comb begin
        wr_ch    = addr[5:3];
        wr_idx   = addr[2:0];
        wr_ok    = we && ({1'b0, wr_ch} < 4'(NCH));
        over     = '0;
        keyon    = '0;
        stop     = '0;
        req      = '0;
        loop_rst = '0;
        mix      = '0;
        dout_nxt = '0;
        for (int c = 0; c < NCH; c++) begin
            over[c]     = div_over(cnt[c], presel[c]);
            keyon[c]    = wr_ok && wr_ch == 3'(c) && wr_idx == 3'd5;
            stop[c]     = wr_ok && wr_ch == 3'(c) && wr_idx == 3'd7 && din[1];
            req[c]      = busy[c] && !valid[c] && !(state == WAIT && cur == IW'(c));
            loop_rst[c] = cen_q && over[c] && busy[c] && valid[c] && sbuf[c][7] && loop_en[c];
            mix         = mix + (11+CW)'(weight(snd_c[c], gain[c]));
            dout_nxt[c] = busy[c];
        end
        {found, pick} = rr_pick(req, last);
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: if (found) begin
                issue     = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: if (!first && rom_ok) begin
                complete  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick     <= '0;
            cen_q    <= 1'b0;
            cen_e    <= 1'b0;
            cur      <= '0;
            last     <= '0;
            first    <= 1'b0;
            discard  <= 1'b0;
            rom_cs   <= 1'b0;
            rom_addr <= '0;
            snd      <= '0;
            dout     <= '0;
            underrun <= '0;
            busy     <= '0;
            valid    <= '0;
            loop_en  <= '0;
            for (int c = 0; c < NCH; c++) begin
                pre[c]    <= '0;
                presel[c] <= '0;
                start[c]  <= '0;
                ptr[c]    <= '0;
                gain[c]   <= '0;
                cnt[c]    <= '0;
                sbuf[c]   <= '0;
                snd_c[c]  <= '0;
            end
        end else begin
            if (cen) tick <= tick + 2'd1;
            cen_q <= cen && tick == 2'd1;
            cen_e <= cen && tick == 2'd3;
            snd   <= mix;
            dout  <= dout_nxt;

            // ROM port: a key-on or stop of the channel being fetched poisons the returned byte
            if (issue) begin
                rom_addr <= ptr[pick];
                rom_cs   <= 1'b1;
                cur      <= pick;
                last     <= pick;
                first    <= 1'b1;
                discard  <= keyon[pick] | stop[pick];
            end else if (state == WAIT) begin
                first <= 1'b0;
                if (complete) rom_cs <= 1'b0;
                if (keyon[cur] | stop[cur]) discard <= 1'b1;
            end

            for (int c = 0; c < NCH; c++) begin
                if (cen_q) cnt[c] <= over[c] ? pre[c] : cnt[c] + 12'd1;
                if (cen_q && over[c]) begin
                    if (!busy[c]) begin
                        snd_c[c] <= '0;
                    end else if (valid[c]) begin
                        snd_c[c] <= sbuf[c][6:0];
                        valid[c] <= 1'b0;
                        if (sbuf[c][7]) begin
                            if (loop_en[c]) ptr[c]  <= start[c];
                            else            busy[c] <= 1'b0;
                        end
                    end else begin
                        underrun[c] <= 1'b1;
                    end
                end
                if (complete && cur == IW'(c) && !discard && !loop_rst[c]) begin
                    sbuf[c]  <= rom_dout;
                    valid[c] <= 1'b1;
                    ptr[c]   <= ptr[c] + AW'(1);
                end
                // Register writes come last so key-on/stop override playback updates
                if (wr_ok && wr_ch == 3'(c)) begin
                    case (wr_idx)
                        3'd0: pre[c][7:0] <= din;
                        3'd1: begin
                            pre[c][11:8] <= din[3:0];
                            presel[c]    <= din[5:4];
                        end
                        3'd2, 3'd3, 3'd4: begin
                            for (int b = 0; b < AW && b < 24; b++)
                                if (3'(b / 8 + 2) == wr_idx) start[c][b] <= din[b % 8];
                        end
                        3'd5: begin
                            busy[c]  <= 1'b1;
                            ptr[c]   <= start[c];
                            valid[c] <= 1'b0;
                            cnt[c]   <= pre[c];
                        end
                        3'd6: gain[c] <= din[3:0];
                        3'd7: begin
                            loop_en[c]  <= din[0];
                            underrun[c] <= 1'b0;
                            if (din[1]) begin
                                busy[c]  <= 1'b0;
                                valid[c] <= 1'b0;
                                snd_c[c] <= '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_jtpcm_nch.sv
// Bench for jtpcm_nch: directed scenarios plus randomized playback checked
// against a sample-sequence model of each channel.
module tb_jtpcm_nch;
    localparam int NCH = 2;
    localparam int AW  = 17;
    localparam int SW  = 12;

    logic clk = 1'b0;
    logic rst, cen, we, rom_ok, cen_e, cen_q, rom_cs;
    logic [5:0]     addr;
    logic [7:0]     din, dout, rom_dout;
    logic [AW-1:0]  rom_addr;
    logic [NCH-1:0] underrun;
    logic [SW-1:0]  snd;

    int n_chk = 0;
    int n_fail = 0;
    int cen_mode = 0;
    int ph = 0;
    int rom_dly = 0;
    int rom_wait = 0;
    logic prev_cs = 1'b0;
    logic [7:0]    rom_tab [512];
    logic [AW-1:0] aq [$];

    logic          m_busy  [NCH];
    logic          m_loop  [NCH];
    logic [AW-1:0] m_ptr   [NCH];
    logic [AW-1:0] m_start [NCH];
    int            m_gain  [NCH];

    jtpcm_nch #(.NCH(NCH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .cen(cen), .addr(addr), .we(we), .din(din),
        .dout(dout), .cen_e(cen_e), .cen_q(cen_q), .rom_addr(rom_addr),
        .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_dout(rom_dout),
        .underrun(underrun), .snd(snd)
    );

    always #5 clk = ~clk;

    // ROM slot with programmable response delay
    always @(posedge clk) rom_wait <= rom_cs ? rom_wait + 1 : 0;
    assign rom_ok   = rom_cs && (rom_wait >= rom_dly);
    assign rom_dout = rom_tab[rom_addr[8:0]];

    always @(negedge clk) begin
        if (rom_cs && !prev_cs) aq.push_back(rom_addr);
        prev_cs <= rom_cs;
    end

    initial begin
        cen = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (cen_mode == 0) cen = 1'b0;
            else begin
                cen = (ph % cen_mode) == 0;
                ph++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int idx, input logic [7:0] d);
        addr = {3'(ch), 3'(idx)};
        din  = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic setup(input int ch, input logic [AW-1:0] st, input int g, input logic lp);
        wr(ch, 0, 8'hFF);
        wr(ch, 1, 8'h0F);
        wr(ch, 2, st[7:0]);
        wr(ch, 3, st[15:8]);
        wr(ch, 4, {7'd0, st[16]});
        wr(ch, 6, 8'(g));
        wr(ch, 7, {7'd0, lp});
        m_start[ch] = st;
        m_ptr[ch]   = st;
        m_gain[ch]  = g;
        m_loop[ch]  = lp;
        m_busy[ch]  = 1'b0;
    endtask

    task automatic keyon(input int ch);
        wr(ch, 5, 8'h00);
        m_busy[ch] = 1'b1;
        m_ptr[ch]  = m_start[ch];
    endtask

    task automatic stop(input int ch);
        wr(ch, 7, 8'h02);
        m_busy[ch] = 1'b0;
        m_loop[ch] = 1'b0;
    endtask

    // Returns once the mix reflects the samples taken on the next Q tick
    task automatic wait_tick();
        int k;
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            if (cen_q) break;
            k++;
        end
        if (k >= 200) check("tick_timeout", 32'(k), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cs(input string tag, input logic val);
        for (int k = 0; k < 300; k++) begin
            if (rom_cs === val) break;
            cyc(1);
        end
        check(tag, 32'(rom_cs), 32'(val));
    endtask

    // One over tick of every channel: each busy channel emits its next stored byte
    task automatic model_tick(output int sum);
        logic [7:0] b;
        sum = 0;
        for (int c = 0; c < NCH; c++) begin
            if (m_busy[c]) begin
                b = rom_tab[m_ptr[c][8:0]];
                sum += int'(b[6:0]) * m_gain[c];
                m_ptr[c] = m_ptr[c] + 1;
                if (b[7]) begin
                    if (m_loop[c]) m_ptr[c] = m_start[c];
                    else           m_busy[c] = 1'b0;
                end
            end
        end
    endtask

    function automatic logic [7:0] m_busyvec();
        logic [7:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) v[c] = m_busy[c];
        return v;
    endfunction

    initial begin
        int qn, qe, both, exp;
        logic [7:0] b;
        logic en [NCH];
        rst = 1'b1; we = 1'b0; addr = '0; din = '0;
        for (int i = 0; i < 512; i++) begin
            b = 8'($urandom_range(0, 127));
            if ($urandom_range(0, 4) == 0) b[7] = 1'b1;
            rom_tab[i] = b;
        end
        for (int c = 0; c < NCH; c++) begin
            m_busy[c] = 0; m_loop[c] = 0; m_ptr[c] = '0; m_start[c] = '0; m_gain[c] = 0;
        end
        cyc(3);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_rom_cs", 32'(rom_cs), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_snd", 32'(snd), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_cen_e", 32'(cen_e), 32'd0);
        check("rst_cen_q", 32'(cen_q), 32'd0);
        rst = 1'b0;
        cyc(2);

        // Tick rates: 40 enables give 10 Q and 10 E pulses, never together
        qn = 0; qe = 0; both = 0;
        cen_mode = 1;
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            qn += int'(cen_q);
            qe += int'(cen_e);
            both += int'(cen_q & cen_e);
            @(posedge clk);
            #1;
            if (i == 39) cen_mode = 0;
        end
        check("cen_q_count", 32'(qn), 32'd10);
        check("cen_e_count", 32'(qe), 32'd10);
        check("cen_qe_overlap", 32'(both), 32'd0);

        wr(3, 5, 8'h00);
        cyc(3);
        check("ignored_ch_busy", 32'(dout), 32'd0);
        check("ignored_ch_fetch", 32'(aq.size()), 32'd0);

        // Single shot 0x10,0x20,0x85 at full gain
        rom_tab[9'h100] = 8'h10; rom_tab[9'h101] = 8'h20; rom_tab[9'h102] = 8'h85;
        aq.delete();
        setup(0, 17'h100, 15, 1'b0);
        keyon(0);
        cyc(10);
        check("one_busy", 32'(dout), 32'd1);
        cen_mode = 4;
        wait_tick(); check("one_s0", 32'(snd), 32'd240);
        wait_tick(); check("one_s1", 32'(snd), 32'd480);
        wait_tick(); check("one_s2", 32'(snd), 32'd75);
        check("one_busy_drop", 32'(dout), 32'd0);
        check("one_nfetch", 32'(aq.size()), 32'd3);
        if (aq.size() >= 3) begin
            check("one_a0", 32'(aq[0]), 32'h100);
            check("one_a1", 32'(aq[1]), 32'h101);
            check("one_a2", 32'(aq[2]), 32'h102);
        end
        wait_tick(); check("one_idle_snd", 32'(snd), 32'd0);
        cen_mode = 0;
        cyc(4);

        // Looping playback
        setup(0, 17'h100, 15, 1'b1);
        keyon(0);
        cyc(10);
        cen_mode = 4;
        for (int r = 0; r < 2; r++) begin
            wait_tick(); check("loop_s0", 32'(snd), 32'd240);
            wait_tick(); check("loop_s1", 32'(snd), 32'd480);
            wait_tick(); check("loop_s2", 32'(snd), 32'd75);
            check("loop_busy", 32'(dout), 32'd1);
        end
        stop(0);
        cen_mode = 0;
        cyc(4);
        check("loop_stopped", 32'(dout), 32'd0);

        // Two channels: fetches alternate, mix is the weighted sum
        for (int i = 0; i < 4; i++) rom_tab[9'h180 + i] = 8'(8'h30 + i);
        aq.delete();
        setup(0, 17'h100, 15, 1'b1);
        setup(1, 17'h180, 3, 1'b0);
        keyon(0);
        keyon(1);
        cyc(12);
        cen_mode = 4;
        wait_tick(); check("rr_s0", 32'(snd), 32'd384);
        wait_tick(); check("rr_s1", 32'(snd), 32'd627);
        check("rr_nfetch", 32'(aq.size() >= 4), 32'd1);
        if (aq.size() >= 4) begin
            check("rr_a0", 32'(aq[0]), 32'h100);
            check("rr_a1", 32'(aq[1]), 32'h180);
            check("rr_a2", 32'(aq[2]), 32'h101);
            check("rr_a3", 32'(aq[3]), 32'h181);
        end
        stop(0);
        stop(1);
        cen_mode = 0;
        cyc(6);

        // Slow ROM: underrun flag, held output, cleared by index 7
        rom_dly = 40;
        setup(0, 17'h100, 15, 1'b0);
        keyon(0);
        cen_mode = 4;
        wait_tick();
        check("ur_flag", 32'(underrun), 32'd1);
        check("ur_snd_held", 32'(snd), 32'd0);
        wr(0, 7, 8'h00);
        check("ur_clear", 32'(underrun), 32'd0);
        stop(0);
        cen_mode = 0;
        rom_dly = 0;
        wait_cs("ur_cs_idle", 1'b0);
        cyc(6);

        // Key-on while the fetch is outstanding: byte dropped, refetch from new start
        rom_tab[9'h150] = 8'h44;
        rom_dly = 20;
        aq.delete();
        setup(0, 17'h100, 7, 1'b0);
        keyon(0);
        wait_cs("kw_cs_up", 1'b1);
        wr(0, 2, 8'h50);
        wr(0, 3, 8'h01);
        m_start[0] = 17'h150;
        keyon(0);
        for (int k = 0; k < 200 && aq.size() < 2; k++) cyc(1);
        check("kw_nfetch", 32'(aq.size() >= 2), 32'd1);
        if (aq.size() >= 2) begin
            check("kw_a0", 32'(aq[0]), 32'h100);
            check("kw_a1", 32'(aq[1]), 32'h150);
        end
        rom_dly = 0;
        wait_cs("kw_cs_idle", 1'b0);
        cyc(4);
        cen_mode = 4;
        wait_tick();
        check("kw_snd", 32'(snd), 32'd476);
        stop(0);
        cen_mode = 0;
        cyc(6);

        // Reset in the middle of a fetch
        rom_dly = 20;
        setup(0, 17'h100, 15, 1'b0);
        keyon(0);
        wait_cs("rf_cs_up", 1'b1);
        cyc(3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("rf_cs", 32'(rom_cs), 32'd0);
        check("rf_dout", 32'(dout), 32'd0);
        check("rf_snd", 32'(snd), 32'd0);
        rom_dly = 0;
        m_busy[0] = 1'b0;
        cyc(30);
        check("rf_busy_late", 32'(dout), 32'd0);
        cen_mode = 4;
        wait_tick();
        check("rf_snd_late", 32'(snd), 32'd0);
        cen_mode = 0;

        // Randomized playback against the sample-sequence model
        for (int it = 0; it < 12; it++) begin
            cyc(4);
            for (int c = 0; c < NCH; c++) begin
                setup(c, AW'($urandom_range(0, 511)), int'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)));
                en[c] = $urandom_range(0, 3) != 0;
            end
            for (int c = 0; c < NCH; c++) if (en[c]) keyon(c);
            cyc(12);
            cen_mode = 4;
            for (int t = 0; t < 8; t++) begin
                wait_tick();
                model_tick(exp);
                check("rnd_snd", 32'(snd), 32'(exp));
                check("rnd_busy", 32'(dout), 32'(m_busyvec()));
            end
            check("rnd_underrun", 32'(underrun), 32'd0);
            for (int c = 0; c < NCH; c++) stop(c);
            cen_mode = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
